// File: rtl/tlight_sched.sv
// tlight_sched: actuated round-robin scheduler for NS, WE and walk phases,
// with min/max green, yellow and all-red clearance timing.
module tlight_sched #(
  parameter int YELLOW_TIME = 3,
  parameter int ALLRED_TIME = 1,
  parameter int MIN_GREEN   = 5,
  parameter int MAX_GREEN   = 20,
  parameter int WALK_TIME   = 8,
  parameter int TIMER_W     = 5
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ns_req,
  input  logic       we_req,
  input  logic       ped_req,
  output logic [2:0] ns,
  output logic [2:0] we,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    ALL_RED   = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    WE_GREEN  = 3'd3,
    WE_YELLOW = 3'd4,
    WALK      = 3'd5
  } state_t;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  localparam logic [TIMER_W-1:0] T_YEL =
    TIMER_W'(YELLOW_TIME - 1);
  localparam logic [TIMER_W-1:0] T_AR =
    TIMER_W'(ALLRED_TIME - 1);
  localparam logic [TIMER_W-1:0] T_WALK =
    TIMER_W'(WALK_TIME - 1);
  localparam logic [TIMER_W-1:0] T_MIN =
    TIMER_W'(MIN_GREEN - 1);
  localparam logic [TIMER_W-1:0] T_MAX =
    TIMER_W'(MAX_GREEN - 1);

  state_t             state;
  state_t             nstate;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] ntimer;
  logic [1:0]         last;
  logic [1:0]         nlast;
  logic [1:0]         c0;
  logic [1:0]         c1;
  logic [1:0]         c2;
  logic [1:0]         gnt;
  logic               gnt_vld;
  logic [3:0]         req;
  logic               tzero;
  logic               gmin;
  logic               gmax;
  logic               own;
  logic               rival;
  logic               enter_walk;

  // requester index: 0 = NS, 1 = WE, 2 = PED
  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  function automatic logic [6:0] lamps(input state_t s);
    unique case (s)
      NS_GREEN:  return {GRN, RED, 1'b0};
      NS_YELLOW: return {YEL, RED, 1'b0};
      WE_GREEN:  return {RED, GRN, 1'b0};
      WE_YELLOW: return {RED, YEL, 1'b0};
      WALK:      return {RED, RED, 1'b1};
      default:   return {RED, RED, 1'b0};
    endcase
  endfunction

  assign req   = {1'b0, ped_pending, we_req, ns_req};
  assign c0    = nxt(last);
  assign c1    = nxt(c0);
  assign c2    = nxt(c1);
  assign tzero = (timer == '0);
  assign gmin  = (timer >= T_MIN);
  assign gmax  = (timer == T_MAX);
  assign own   = (state == NS_GREEN) ? ns_req : we_req;
  assign rival = ped_pending |
    ((state == NS_GREEN) ? we_req : ns_req);
  assign enter_walk =
    (nstate == WALK) && (state != WALK);
  assign phase = state;

  always_comb begin
    gnt_vld = |req;
    gnt     = c2;
    if (req[c0])      gnt = c0;
    else if (req[c1]) gnt = c1;
  end

  always_comb begin
    nstate = state;
    ntimer = timer;
    nlast  = last;
    case (state)
      ALL_RED: begin
        if (!tzero) begin
          ntimer = timer - 1'b1;
        end else if (gnt_vld) begin
          nlast  = gnt;
          ntimer = '0;
          if (gnt == 2'd0) begin
            nstate = NS_GREEN;
          end else if (gnt == 2'd1) begin
            nstate = WE_GREEN;
          end else begin
            nstate = WALK;
            ntimer = T_WALK;
          end
        end
      end
      NS_GREEN, WE_GREEN: begin
        if (gmin && rival && (!own || gmax)) begin
          nstate = (state == NS_GREEN) ?
            NS_YELLOW : WE_YELLOW;
          ntimer = T_YEL;
        end else if (!gmax) begin
          ntimer = timer + 1'b1;
        end
      end
      NS_YELLOW, WE_YELLOW, WALK: begin
        if (tzero) begin
          nstate = ALL_RED;
          ntimer = T_AR;
        end else begin
          ntimer = timer - 1'b1;
        end
      end
      default: begin
        nstate = ALL_RED;
        ntimer = T_AR;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ALL_RED;
      timer       <= T_AR;
      last        <= 2'd2;
      ped_pending <= 1'b0;
      ns          <= RED;
      we          <= RED;
      walk        <= 1'b0;
    end else begin
      state       <= nstate;
      timer       <= ntimer;
      last        <= nlast;
      ped_pending <= ped_req |
        (ped_pending & ~enter_walk);
      {ns, we, walk} <= lamps(nstate);
    end
  end

endmodule

// File: tb/tb_tlight_sched.sv
// tb_tlight_sched: directed and random stimulus checked against a
// phase/age reference model of the intersection scheduler.
module tb_tlight_sched;

  localparam int YT   = 3;
  localparam int AT   = 1;
  localparam int MING = 5;
  localparam int MAXG = 20;
  localparam int WT   = 8;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b1;
  logic       ns_req  = 1'b0;
  logic       we_req  = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] ns;
  logic [2:0] we;
  logic [2:0] phase;
  logic       walk;
  logic       ped_pending;

  int nvec = 0;
  int nerr = 0;

  typedef enum logic [2:0] {
    M_AR, M_NSG, M_NSY, M_WEG, M_WEY, M_WALK
  } mph_t;

  mph_t m_ph;
  int   m_age;
  int   m_last;
  bit   m_ped;

  tlight_sched #(
    .YELLOW_TIME(YT),
    .ALLRED_TIME(AT),
    .MIN_GREEN(MING),
    .MAX_GREEN(MAXG),
    .WALK_TIME(WT),
    .TIMER_W(5)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .ns_req(ns_req),
    .we_req(we_req),
    .ped_req(ped_req),
    .ns(ns),
    .we(we),
    .walk(walk),
    .ped_pending(ped_pending),
    .phase(phase)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ph   = M_AR;
    m_age  = 0;
    m_last = 2;
    m_ped  = 1'b0;
  endtask

  function automatic int dur(input mph_t p);
    if (p == M_AR) return AT;
    if (p == M_NSY || p == M_WEY) return YT;
    return WT;
  endfunction

  // one clock of the reference: age = cycles already spent in the phase
  task automatic model_step();
    bit   r[3];
    int   g;
    int   c;
    bit   own;
    bit   rival;
    mph_t nx;
    nx   = m_ph;
    r[0] = ns_req;
    r[1] = we_req;
    r[2] = m_ped;
    case (m_ph)
      M_AR: begin
        if (m_age >= AT - 1) begin
          g = -1;
          for (int k = 1; k <= 3; k++) begin
            c = (m_last + k) % 3;
            if (g < 0 && r[c]) g = c;
          end
          if (g >= 0) begin
            m_last = g;
            if (g == 0) nx = M_NSG;
            else if (g == 1) nx = M_WEG;
            else nx = M_WALK;
          end
        end
      end
      M_NSG, M_WEG: begin
        own   = (m_ph == M_NSG) ? ns_req : we_req;
        rival = m_ped ||
          ((m_ph == M_NSG) ? we_req : ns_req);
        if (m_age >= MING - 1 && rival &&
            (!own || m_age >= MAXG - 1)) begin
          if (m_ph == M_NSG) nx = M_NSY;
          else nx = M_WEY;
        end
      end
      default: begin
        if (m_age >= dur(m_ph) - 1) nx = M_AR;
      end
    endcase
    m_ped = ped_req ||
      (m_ped && !(nx == M_WALK && m_ph != M_WALK));
    if (nx != m_ph) m_age = 0;
    else m_age++;
    m_ph = nx;
  endtask

  task automatic check_all(input string tag);
    logic [2:0] en;
    logic [2:0] ew;
    logic       ewk;
    en  = RED;
    ew  = RED;
    ewk = 1'b0;
    case (m_ph)
      M_NSG:   en  = GRN;
      M_NSY:   en  = YEL;
      M_WEG:   ew  = GRN;
      M_WEY:   ew  = YEL;
      M_WALK:  ewk = 1'b1;
      default: ;
    endcase
    chk({tag, ".ns"}, ns, en);
    chk({tag, ".we"}, we, ew);
    chk({tag, ".walk"}, walk, ewk);
    chk({tag, ".pend"}, ped_pending, m_ped);
    chk({tag, ".excl"},
        (ns == RED) || (we == RED), 1);
  endtask

  task automatic cyc(input string tag);
    @(posedge clock);
    if (!reset_n) model_reset();
    else model_step();
    @(negedge clock);
    check_all(tag);
  endtask

  task automatic do_reset(input bit n, input bit w);
    @(negedge clock);
    #1;
    reset_n = 1'b0;
    ns_req  = n;
    we_req  = w;
    ped_req = 1'b0;
    #1;
    model_reset();
    check_all("rst");
    cyc("rst_hold");
    reset_n = 1'b1;
  endtask

  function automatic int gtype();
    if (ns == GRN) return 1;
    if (we == GRN) return 2;
    if (walk) return 3;
    return 0;
  endfunction

  initial begin
    int glen;
    int ylen;
    int alen;
    int wlen;
    int g;
    int prev;
    int q[$];

    model_reset();
    #2;
    ns_req  = 1'b1;
    reset_n = 1'b0;
    #1;
    check_all("por");
    cyc("por_hold");
    reset_n = 1'b1;

    cyc("first");
    chk("first_grant", ns, GRN);
    repeat (50) cyc("dwell");
    chk("dwell_end", ns, GRN);

    do_reset(1'b1, 1'b1);
    cyc("maxg");
    glen = 1;
    for (int i = 0; i < 40; i++) begin
      cyc("maxg");
      if (ns == GRN) glen++;
      else break;
    end
    chk("maxg_len", glen, MAXG);
    ylen = 1;
    for (int i = 0; i < 10; i++) begin
      cyc("maxg_y");
      if (ns == YEL) ylen++;
      else break;
    end
    chk("yel_len", ylen, YT);
    alen = 1;
    for (int i = 0; i < 10; i++) begin
      cyc("maxg_ar");
      if (ns == RED && we == RED) alen++;
      else break;
    end
    chk("ar_len", alen, AT);
    chk("we_after", we, GRN);

    do_reset(1'b1, 1'b0);
    cyc("gap");
    cyc("gap");
    ns_req = 1'b0;
    we_req = 1'b1;
    glen = 2;
    for (int i = 0; i < 40; i++) begin
      cyc("gap");
      if (ns == GRN) glen++;
      else break;
    end
    chk("min_green", glen, MING);

    do_reset(1'b1, 1'b1);
    cyc("ped");
    ped_req = 1'b1;
    cyc("ped");
    ped_req = 1'b0;
    prev = 1;
    wlen = 0;
    for (int i = 0; i < 200; i++) begin
      cyc("ped");
      g = gtype();
      if (walk) wlen++;
      if (g != prev && g != 0) q.push_back(g);
      prev = g;
      if (q.size() == 3) break;
    end
    while (q.size() < 3) q.push_back(0);
    chk("rot0", q[0], 2);
    chk("rot1", q[1], 3);
    chk("rot2", q[2], 1);
    chk("walk_len", wlen, WT);

    for (int i = 0; i < 100; i++) begin
      if (ns == YEL) break;
      cyc("to_yel");
    end
    chk("reach_yel", ns, YEL);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_ns", ns, RED);
    chk("midrst_we", we, RED);
    check_all("midrst");
    ns_req = 1'b0;
    we_req = 1'b0;
    cyc("midrst_hold");
    reset_n = 1'b1;
    repeat (30) cyc("idle");
    chk("idle_ns", ns, RED);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(5) == 0) ns_req = ~ns_req;
      if ($urandom_range(5) == 0) we_req = ~we_req;
      ped_req = ($urandom_range(15) == 0);
      cyc("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
